// File: rtl/artemis_ddr3_stream_writer_if.sv
// Stream-in and MCB user-port (pN_cmd / pN_wr) signals of the Artemis DDR3 stream writer.
// The master modport is the writer; the slave modport is the stream source plus the MCB port.
interface artemis_ddr3_stream_writer_if;
  logic [31:0] i_data;
  logic        i_data_stb;
  logic        o_data_rdy;
  logic        o_cmd_en;
  logic [2:0]  o_cmd_instr;
  logic [5:0]  o_cmd_bl;
  logic [29:0] o_cmd_byte_addr;
  logic        i_cmd_full;
  logic        o_wr_en;
  logic [3:0]  o_wr_mask;
  logic [31:0] o_wr_data;
  logic        i_wr_full;
  logic        i_wr_underrun;
  logic        i_wr_error;

  modport master (
    input  i_data, i_data_stb, i_cmd_full, i_wr_full, i_wr_underrun, i_wr_error,
    output o_data_rdy, o_cmd_en, o_cmd_instr, o_cmd_bl, o_cmd_byte_addr,
           o_wr_en, o_wr_mask, o_wr_data
  );

  modport slave (
    output i_data, i_data_stb, i_cmd_full, i_wr_full, i_wr_underrun, i_wr_error,
    input  o_data_rdy, o_cmd_en, o_cmd_instr, o_cmd_bl, o_cmd_byte_addr,
           o_wr_en, o_wr_mask, o_wr_data
  );
endinterface

// File: rtl/artemis_ddr3_stream_writer.sv
// Fills the MCB write FIFO one burst at a time from a 32-bit stream, then issues one write command per burst.
// Define ARTEMIS_WRITER_AUTO_PRECHARGE_EN to issue write-with-auto-precharge instead of plain writes.
module artemis_ddr3_stream_writer #(
  parameter int unsigned BURST_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_calibration_done,
  input  logic        i_start,
  input  logic [29:0] i_base_addr,
  input  logic [23:0] i_word_count,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  artemis_ddr3_stream_writer_if.master bus
);

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned CNT_W  = 24;
  localparam int unsigned BEAT_W = 7;

`ifdef ARTEMIS_WRITER_AUTO_PRECHARGE_EN
  localparam logic [2:0] CMD_INSTR = 3'b010;
`else
  localparam logic [2:0] CMD_INSTR = 3'b000;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_CMD} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [BEAT_W-1:0]   fill_q, fill_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [BEAT_W-1:0]   beats_c;
  logic                data_rdy_c;
  logic                wr_en_c;
  logic                cmd_en_c;

  // Beats in the current burst: a full burst, or whatever is left for the final one.
  assign beats_c = (remaining_q < CNT_W'(BURST_WORDS)) ? BEAT_W'(remaining_q)
                                                       : BEAT_W'(BURST_WORDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      fill_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      fill_q      <= fill_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    fill_d      = fill_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    data_rdy_c  = 1'b0;
    wr_en_c     = 1'b0;
    cmd_en_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start && i_calibration_done && (i_word_count != '0)) begin
          addr_d      = i_base_addr & ~ADDR_W'(3);
          remaining_d = i_word_count;
          fill_d      = '0;
          error_d     = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_FILL;
        end
      end

      ST_FILL: begin
        data_rdy_c = !bus.i_wr_full && (fill_q < beats_c);
        if (bus.i_data_stb && data_rdy_c) begin
          wr_en_c = 1'b1;
          fill_d  = BEAT_W'(fill_q + BEAT_W'(1));
        end
        if (fill_d == beats_c) begin
          state_d = ST_CMD;
        end
      end

      ST_CMD: begin
        // The burst's data is already in the FIFO, so the command can never cause an underrun.
        if (!bus.i_cmd_full) begin
          cmd_en_c    = 1'b1;
          addr_d      = addr_q + ADDR_W'({beats_c, 2'b00});
          remaining_d = remaining_q - CNT_W'(beats_c);
          fill_d      = '0;
          if (remaining_d == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FILL;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // MCB fault aborts the transfer without a done pulse; the error flag holds until the next start.
    if (busy_q && (bus.i_wr_underrun || bus.i_wr_error)) begin
      error_d = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      state_d = ST_IDLE;
    end
  end

  assign o_busy              = busy_q;
  assign o_done              = done_q;
  assign o_error             = error_q;
  assign bus.o_data_rdy      = data_rdy_c;
  assign bus.o_wr_en         = wr_en_c;
  assign bus.o_wr_data       = bus.i_data;
  assign bus.o_wr_mask       = 4'b0000;
  assign bus.o_cmd_en        = cmd_en_c;
  assign bus.o_cmd_instr     = CMD_INSTR;
  assign bus.o_cmd_bl        = (state_q == ST_CMD) ? 6'(beats_c - BEAT_W'(1)) : 6'd0;
  assign bus.o_cmd_byte_addr = addr_q;

endmodule
